// File: rtl/fpu_tile_pkg.sv
// Shared constants and types for the FPU tile initiator.
// Holds the tile command encodings and the initiator FSM state type.
package fpu_tile_pkg;

  localparam int CSR_START_BIT = 15;
  localparam int CSR_SUB_BIT   = 4;

  localparam logic [15:0] CSR_CMD_ADD = 16'h8000;
  localparam logic [15:0] CSR_CMD_SUB = 16'h8010;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } init_state_e;

  function automatic logic [15:0] cmd_word(input logic sub);
    return sub ? CSR_CMD_SUB : CSR_CMD_ADD;
  endfunction

endpackage

// File: rtl/fpu_tile_initiator_if.sv
// Request/response and tile CSR/data bundle for the FPU tile initiator.
// The master modport is the initiator's view; slave is the host+tile environment.
interface fpu_tile_initiator_if #(
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int REG_WIDTH     = 32
) ();

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_sub;
  logic [REG_WIDTH-1:0]     req_a;
  logic [REG_WIDTH-1:0]     req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [REG_WIDTH-1:0]     rsp_c;
  logic [CSR_OUT_WIDTH-1:0] rsp_status;
  logic                     rsp_timeout;
  logic                     err_spurious;
  logic [CSR_IN_WIDTH-1:0]  csr_in;
  logic                     csr_in_re;
  logic [REG_WIDTH-1:0]     data_reg_a;
  logic [REG_WIDTH-1:0]     data_reg_b;
  logic [CSR_OUT_WIDTH-1:0] csr_out;
  logic                     csr_out_we;
  logic [REG_WIDTH-1:0]     data_reg_c;

  modport master (
    input  req_valid, req_sub, req_a, req_b, rsp_ready,
    input  csr_in_re, csr_out, csr_out_we, data_reg_c,
    output req_ready, rsp_valid, rsp_c, rsp_status, rsp_timeout, err_spurious,
    output csr_in, data_reg_a, data_reg_b
  );

  modport slave (
    output req_valid, req_sub, req_a, req_b, rsp_ready,
    output csr_in_re, csr_out, csr_out_we, data_reg_c,
    input  req_ready, rsp_valid, rsp_c, rsp_status, rsp_timeout, err_spurious,
    input  csr_in, data_reg_a, data_reg_b
  );

endinterface

// File: rtl/fpu_tile_watchdog.sv
// Wait-state cycle counter for the FPU tile initiator (used with FPU_INIT_TIMEOUT_EN).
// expired_o fires during the TIMEOUT_CYCLES-th consecutive running cycle after clear.
module fpu_tile_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a stalled FSM cannot wrap the counter.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/fpu_tile_initiator.sv
// Host-side initiator for one FPU ip_tile: issues one add/sub at a time over CSR/data regs.
// Optional watchdog enabled by defining FPU_INIT_TIMEOUT_EN.
module fpu_tile_initiator
  import fpu_tile_pkg::*;
#(
  parameter int CSR_IN_WIDTH   = 16,
  parameter int CSR_OUT_WIDTH  = 16,
  parameter int REG_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                 clk,
  input logic                 arst_n,
  fpu_tile_initiator_if.master bus
);

  init_state_e              state_q, state_d;
  logic                     req_ready_q, req_ready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     timeout_q, timeout_d;
  logic                     err_q, err_d;
  logic [CSR_IN_WIDTH-1:0]  csr_in_q, csr_in_d;
  logic [REG_WIDTH-1:0]     a_q, a_d;
  logic [REG_WIDTH-1:0]     b_q, b_d;
  logic [REG_WIDTH-1:0]     c_q, c_d;
  logic [CSR_OUT_WIDTH-1:0] status_q, status_d;
  logic                     accept;
  logic                     wd_expired;

  assign accept = (state_q == IDLE) && bus.req_valid && req_ready_q;

`ifdef FPU_INIT_TIMEOUT_EN
  fpu_tile_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .arst_n   (arst_n),
    .clear_i  (accept),
    .run_i    ((state_q == WAIT_ACK) || (state_q == WAIT_DONE)),
    .expired_o(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    csr_in_d    = csr_in_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    status_d    = status_q;
    case (state_q)
      IDLE: begin
        if (bus.csr_out_we) err_d = 1'b1;
        if (accept) begin
          a_d         = bus.req_a;
          b_d         = bus.req_b;
          csr_in_d    = CSR_IN_WIDTH'(cmd_word(bus.req_sub));
          req_ready_d = 1'b0;
          timeout_d   = 1'b0;
          state_d     = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.csr_in_re) begin
          csr_in_d = '0;
          if (bus.csr_out_we) begin
            c_d         = bus.data_reg_c;
            status_d    = bus.csr_out;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            state_d = WAIT_DONE;
          end
        end else if (wd_expired) begin
          csr_in_d    = '0;
          c_d         = REG_WIDTH'(FP_QNAN);
          status_d    = '0;
          timeout_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      WAIT_DONE: begin
        // A real completion in the expiry cycle still wins over the watchdog.
        if (bus.csr_out_we) begin
          c_d         = bus.data_reg_c;
          status_d    = bus.csr_out;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (wd_expired) begin
          csr_in_d    = '0;
          c_d         = REG_WIDTH'(FP_QNAN);
          status_d    = '0;
          timeout_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.csr_out_we) err_d = 1'b1;
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
      csr_in_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      csr_in_q    <= csr_in_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      status_q    <= status_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_c        = c_q;
  assign bus.rsp_status   = status_q;
  assign bus.rsp_timeout  = timeout_q;
  assign bus.err_spurious = err_q;
  assign bus.csr_in       = csr_in_q;
  assign bus.data_reg_a   = a_q;
  assign bus.data_reg_b   = b_q;

endmodule

// File: tb/tb_fpu_tile_initiator.sv
// Testbench for fpu_tile_initiator: the bench plays both the host and the ip_tile.
// Expected responses come from a queue of what the tile model produced.
module tb_fpu_tile_initiator;

  logic clk;
  logic arst_n;
  int   nvec;
  int   nerr;

  logic [31:0] exp_c_q[$];
  logic [15:0] exp_st_q[$];

  fpu_tile_initiator_if bus ();

  fpu_tile_initiator dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_sub    = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 1'b0;
    bus.csr_in_re  = 1'b0;
    bus.csr_out    = '0;
    bus.csr_out_we = 1'b0;
    bus.data_reg_c = '0;
  endtask

  // One full transaction; done_dly==0 means completion in the same cycle as the ack.
  task automatic run_op(input string nm, input logic sub, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [15:0] st,
                        input int ack_dly, input int done_dly, input int bp);
    logic [15:0] cmd;
    logic [31:0] ec;
    logic [15:0] es;
    cmd = sub ? 16'h8010 : 16'h8000;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_sub = sub; bus.req_a = a; bus.req_b = b;
    nvec++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL %s req_ready got %b exp 1", nm, bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_sub = ~sub; bus.req_a = $urandom; bus.req_b = $urandom;
    nvec++; if (bus.csr_in !== cmd) begin nerr++; $display("FAIL %s csr_in got %h exp %h", nm, bus.csr_in, cmd); end
    nvec++; if (bus.data_reg_a !== a) begin nerr++; $display("FAIL %s data_reg_a got %h exp %h", nm, bus.data_reg_a, a); end
    nvec++; if (bus.data_reg_b !== b) begin nerr++; $display("FAIL %s data_reg_b got %h exp %h", nm, bus.data_reg_b, b); end
    nvec++; if (bus.req_ready !== 1'b0) begin nerr++; $display("FAIL %s req_ready busy got %b exp 0", nm, bus.req_ready); end
    for (int i = 0; i < ack_dly; i++) begin
      bus.data_reg_c = $urandom; bus.csr_out = 16'($urandom);
      @(negedge clk);
      nvec++; if (bus.csr_in !== cmd) begin nerr++; $display("FAIL %s csr_in hold got %h exp %h", nm, bus.csr_in, cmd); end
      nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL %s early rsp_valid got %b exp 0", nm, bus.rsp_valid); end
    end
    bus.csr_in_re = 1'b1;
    if (done_dly == 0) begin
      bus.csr_out_we = 1'b1; bus.data_reg_c = c; bus.csr_out = st;
      exp_c_q.push_back(c); exp_st_q.push_back(st);
    end
    @(negedge clk);
    bus.csr_in_re = 1'b0; bus.csr_out_we = 1'b0;
    bus.data_reg_c = $urandom; bus.csr_out = 16'($urandom);
    nvec++; if (bus.csr_in !== 16'h0000) begin nerr++; $display("FAIL %s csr_in after ack got %h exp 0000", nm, bus.csr_in); end
    nvec++; if (bus.data_reg_a !== a) begin nerr++; $display("FAIL %s data_reg_a kept got %h exp %h", nm, bus.data_reg_a, a); end
    if (done_dly > 0) begin
      for (int i = 1; i < done_dly; i++) begin
        nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL %s wait rsp_valid got %b exp 0", nm, bus.rsp_valid); end
        @(negedge clk);
        bus.data_reg_c = $urandom; bus.csr_out = 16'($urandom);
      end
      nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL %s pre-done rsp_valid got %b exp 0", nm, bus.rsp_valid); end
      bus.csr_out_we = 1'b1; bus.data_reg_c = c; bus.csr_out = st;
      exp_c_q.push_back(c); exp_st_q.push_back(st);
      @(negedge clk);
      bus.csr_out_we = 1'b0; bus.data_reg_c = $urandom; bus.csr_out = 16'($urandom);
    end
    ec = exp_c_q.pop_front();
    es = exp_st_q.pop_front();
    nvec++; if (bus.rsp_valid !== 1'b1) begin nerr++; $display("FAIL %s rsp_valid got %b exp 1", nm, bus.rsp_valid); end
    nvec++; if (bus.rsp_c !== ec) begin nerr++; $display("FAIL %s rsp_c got %h exp %h", nm, bus.rsp_c, ec); end
    nvec++; if (bus.rsp_status !== es) begin nerr++; $display("FAIL %s rsp_status got %h exp %h", nm, bus.rsp_status, es); end
    nvec++; if (bus.rsp_timeout !== 1'b0) begin nerr++; $display("FAIL %s rsp_timeout got %b exp 0", nm, bus.rsp_timeout); end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      bus.data_reg_c = $urandom; bus.csr_out = 16'($urandom);
      nvec++; if (bus.rsp_valid !== 1'b1) begin nerr++; $display("FAIL %s bp rsp_valid got %b exp 1", nm, bus.rsp_valid); end
      nvec++; if (bus.rsp_c !== ec) begin nerr++; $display("FAIL %s bp rsp_c got %h exp %h", nm, bus.rsp_c, ec); end
      nvec++; if (bus.rsp_status !== es) begin nerr++; $display("FAIL %s bp rsp_status got %h exp %h", nm, bus.rsp_status, es); end
      nvec++; if (bus.req_ready !== 1'b0) begin nerr++; $display("FAIL %s bp req_ready got %b exp 0", nm, bus.req_ready); end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL %s rsp_valid after hs got %b exp 0", nm, bus.rsp_valid); end
    nvec++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL %s req_ready after hs got %b exp 1", nm, bus.req_ready); end
  endtask

  task automatic test_reset();
    idle_inputs();
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL reset req_ready got %b exp 1", bus.req_ready); end
    nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL reset rsp_valid got %b exp 0", bus.rsp_valid); end
    nvec++; if (bus.csr_in !== 16'h0) begin nerr++; $display("FAIL reset csr_in got %h exp 0", bus.csr_in); end
    nvec++; if (bus.err_spurious !== 1'b0) begin nerr++; $display("FAIL reset err got %b exp 0", bus.err_spurious); end
    nvec++; if (bus.rsp_timeout !== 1'b0) begin nerr++; $display("FAIL reset rsp_timeout got %b exp 0", bus.rsp_timeout); end
    nvec++; if ({bus.data_reg_a, bus.data_reg_b, bus.rsp_c} !== 96'h0) begin nerr++; $display("FAIL reset data got %h exp 0", {bus.data_reg_a, bus.data_reg_b, bus.rsp_c}); end
    arst_n = 1'b1;
    @(negedge clk);
    nvec++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL post-reset req_ready got %b exp 1", bus.req_ready); end
  endtask

  task automatic test_add();
    run_op("add", 1'b0, 32'h41200000, 32'h40A00000, 32'h41700000, 16'h0001, 1, 3, 0);
  endtask

  task automatic test_sub();
    run_op("sub", 1'b1, 32'h41600000, 32'h40A00000, 32'h41100000, 16'h00A5, 1, 2, 0);
  endtask

  task automatic test_backpressure();
    run_op("bp", 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 16'h5A5A, 0, 1, 5);
  endtask

  task automatic test_same_cycle();
    run_op("same", 1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, 16'hC3C3, 0, 0, 0);
    run_op("same_dly", 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'hDEADBEEF, 16'hFFFF, 2, 0, 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      run_op("rand", 1'($urandom), $urandom, $urandom, $urandom, 16'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end
    nvec++; if (bus.err_spurious !== 1'b0) begin nerr++; $display("FAIL rand err got %b exp 0", bus.err_spurious); end
  endtask

  task automatic test_ignored_ack();
    @(negedge clk);
    bus.csr_in_re = 1'b1;
    @(negedge clk);
    bus.csr_in_re = 1'b0;
    nvec++; if (bus.csr_in !== 16'h0) begin nerr++; $display("FAIL ign_ack csr_in got %h exp 0", bus.csr_in); end
    nvec++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL ign_ack req_ready got %b exp 1", bus.req_ready); end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    bus.csr_out_we = 1'b1; bus.data_reg_c = 32'hCAFEF00D;
    @(negedge clk);
    bus.csr_out_we = 1'b0;
    nvec++; if (bus.err_spurious !== 1'b1) begin nerr++; $display("FAIL spur err got %b exp 1", bus.err_spurious); end
    nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL spur rsp_valid got %b exp 0", bus.rsp_valid); end
    repeat (3) @(negedge clk);
    nvec++; if (bus.err_spurious !== 1'b1) begin nerr++; $display("FAIL spur sticky got %b exp 1", bus.err_spurious); end
    run_op("spur_op", 1'b0, 32'h1, 32'h2, 32'h3, 16'h4, 0, 1, 0);
    nvec++; if (bus.err_spurious !== 1'b1) begin nerr++; $display("FAIL spur after op got %b exp 1", bus.err_spurious); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_sub = 1'b1; bus.req_a = 32'h11111111; bus.req_b = 32'h22222222;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.csr_in_re = 1'b1;
    @(negedge clk);
    bus.csr_in_re = 1'b0;
    #2 arst_n = 1'b0;
    #1;
    nvec++; if (bus.csr_in !== 16'h0) begin nerr++; $display("FAIL rstmid csr_in got %h exp 0", bus.csr_in); end
    nvec++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL rstmid req_ready got %b exp 1", bus.req_ready); end
    nvec++; if (bus.err_spurious !== 1'b0) begin nerr++; $display("FAIL rstmid err got %b exp 0", bus.err_spurious); end
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL rstmid rsp_valid got %b exp 0", bus.rsp_valid); end
    end
    run_op("rstmid_op", 1'b0, 32'hAAAA5555, 32'h5555AAAA, 32'h0F0F0F0F, 16'h00F0, 1, 1, 0);
  endtask

`ifdef FPU_INIT_TIMEOUT_EN
  task automatic test_timeout();
    int waited;
    bit seen;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_a = 32'h1; bus.req_b = 32'h2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 300) begin
      @(negedge clk);
      waited++;
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    nvec++; if (!seen) begin nerr++; $display("FAIL tmo rsp_valid got none in %0d cycles exp within 300", waited); end
    nvec++; if (bus.rsp_c !== 32'h7FC00000) begin nerr++; $display("FAIL tmo rsp_c got %h exp 7fc00000", bus.rsp_c); end
    nvec++; if (bus.rsp_status !== 16'h0) begin nerr++; $display("FAIL tmo rsp_status got %h exp 0", bus.rsp_status); end
    nvec++; if (bus.rsp_timeout !== 1'b1) begin nerr++; $display("FAIL tmo rsp_timeout got %b exp 1", bus.rsp_timeout); end
    nvec++; if (bus.csr_in !== 16'h0) begin nerr++; $display("FAIL tmo csr_in got %h exp 0", bus.csr_in); end
    bus.csr_out_we = 1'b1;
    @(negedge clk);
    bus.csr_out_we = 1'b0;
    nvec++; if (bus.err_spurious !== 1'b1) begin nerr++; $display("FAIL tmo late err got %b exp 1", bus.err_spurious); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL tmo hs rsp_valid got %b exp 0", bus.rsp_valid); end
  endtask
`endif

  initial begin
    nvec   = 0;
    nerr   = 0;
    arst_n = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_same_cycle();
    test_random();
    test_ignored_ack();
    test_spurious();
    test_reset_mid();
`ifdef FPU_INIT_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
